expansion_rom_arbiter: RTL and testbench
========================================

Name: expansion_rom_arbiter

Overview:
Tracks which peripheral slot owns the shared $C800-$CFFF expansion-ROM window. Cards such as the Super Serial Card no longer keep private C8 flags. Ownership is set on each slot's $Cn00-$CnFF access and released on $CFFF. The block also drives per-slot ROM enables, arbitrates card read data onto the bus with fixed priority, and combines card interrupts. It sits in the multicard framework between the bus interface and the slot card instances.

Parameters:
NUM_SLOTS, 8, width of the per-slot vectors; slot 0 is never a ROM owner, usable slots are 1..7.
CONFLICT_CNT_W, 8, width of the saturating read-conflict counter.

Ports:
clk_logic  input  1  logic clock.
system_reset_n  input  1  asynchronous active-low reset.
bus_strobe_i  input  1  one-cycle pulse when addr_i/rw_n_i are valid for a new bus cycle.
addr_i  input  16  Apple II address bus.
rw_n_i  input  1  1 = read.
intcxrom_i  input  1  internal $C100-$CFFF ROM selected.
slotc3rom_i  input  1  0 = internal ROM at $C300.
slot_enable_i  input  NUM_SLOTS  card present/enabled per slot.
rom_present_i  input  NUM_SLOTS  card implements a C8 expansion ROM.
card_rd_en_i  input  NUM_SLOTS  card wants to drive read data.
card_data_i  input  8*NUM_SLOTS  card read data; slot n at bits [8n+7:8n].
card_irq_n_i  input  NUM_SLOTS  active-low card interrupts.
rom_sel_o  output  NUM_SLOTS  one-hot C8 ROM enable, combinational from addr_i.
owner_valid_o  output  1  an owner is latched.
owner_slot_o  output  3  owning slot; 0 when none.
data_o  output  8  arbitrated read data, registered.
rd_en_o  output  1  drive bus, registered.
conflict_o  output  1  one-cycle pulse on multi-driver read.
conflict_cnt_o  output  CONFLICT_CNT_W  saturating conflict count.
irq_n_o  output  1  combined interrupt, registered.
irq_slot_o  output  3  lowest pending interrupt slot; 0 when none.

Behaviour:
- Reset (async assert, sync release) values: owner_valid_o=0, owner_slot_o=0, data_o=8'hFF, rd_en_o=0, conflict_o=0, conflict_cnt_o=0, irq_n_o=1, irq_slot_o=0.
- Ownership FSM has two states, IDLE (no owner) and OWNED(n). It updates only on bus_strobe_i; the new owner is visible the following cycle.
  - Claim condition: addr_i[15:8]==8'hCn with n in 1..7, intcxrom_i=0, slot_enable_i[n]=1, rom_present_i[n]=1, and not (n==3 and slotc3rom_i=0). When the condition holds, the FSM goes to OWNED(n) from any state, so a claim by another slot transfers ownership.
  - Release: addr_i==16'hCFFF for reads or writes, regardless of intcxrom_i, sends the FSM to IDLE.
  - A claim attempt that fails the condition leaves the state unchanged.
  - If slot_enable_i[owner] drops in any cycle, the FSM goes to IDLE on the next clock edge without waiting for a strobe.
- rom_sel_o[n]=1 only when owner_valid_o=1, owner_slot_o=n, addr_i in $C800-$CFFF, and intcxrom_i=0. All other bits are 0, and bit 0 is always 0.
- An access to $CFFF still asserts rom_sel_o for the current owner during that cycle. Release takes effect the cycle after the strobe.
- Read arbitration is evaluated every cycle:
  - Requests are req = card_rd_en_i & slot_enable_i & {NUM_SLOTS{rw_n_i}}.
  - The lowest-numbered requesting slot wins.
  - Next cycle: rd_en_o = |req and data_o = winner data. With no request, rd_en_o=0 and data_o=8'hFF.
  - Latency is 1 clock.
- Conflict: if popcount(req)>=2, conflict_o pulses for 1 cycle together with the registered output, and conflict_cnt_o increments by 1, saturating at all-ones.
- Interrupts are evaluated every cycle:
  - Pending = ~card_irq_n_i & slot_enable_i.
  - Next cycle: irq_n_o = ~|pending and irq_slot_o = lowest pending slot index (0 when none).
  - Slot 0 pending reports irq_slot_o=0 with irq_n_o=0.
- Reset asserted mid-cycle clears ownership immediately. No claim is latched from a strobe concurrent with reset.

Test Plan:
- Strobe at $C200 (slot 2 enabled, ROM present, intcxrom_i=0) -> next cycle owner_slot_o=2, owner_valid_o=1. Then addr $C900 -> rom_sel_o=8'b0000_0100. Then strobe at $CFFF -> rom_sel_o[2]=1 during that cycle, owner_valid_o=0 the cycle after.
- Owned by 2, strobe $C500 (slot 5 valid) -> owner_slot_o=5. Strobe $C600 with rom_present_i[6]=0 -> owner stays 5. Strobe $C300 with slotc3rom_i=0 -> owner stays 5.
- intcxrom_i=1, strobe $C200 -> no claim. With owner 2 and intcxrom_i=1, addr $C900 -> rom_sel_o=0.
- card_rd_en_i=8'b0010_1000 with card_data_i slot3=8'hA5 and slot5=8'h5A, rw_n_i=1 -> next cycle data_o=8'hA5, rd_en_o=1, conflict_o=1, conflict_cnt_o=1. Repeat 300 times -> counter saturates at 255.
- card_irq_n_i slots 4 and 6 low, all slots enabled -> irq_n_o=0, irq_slot_o=4. Disable slot 4 -> irq_slot_o=6. Release both -> irq_n_o=1, irq_slot_o=0.
- Owner 2, deassert slot_enable_i[2] with no strobe -> owner_valid_o=0 next cycle. Assert reset while owned -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/expansion_rom_arbiter.sv
// Shared $C800-$CFFF expansion-ROM ownership tracking, per-slot ROM enables,
// fixed-priority card read-data arbitration and interrupt combining.
module expansion_rom_arbiter #(
    parameter int NUM_SLOTS      = 8,
    parameter int CONFLICT_CNT_W = 8
) (
    input  logic                      clk_logic,
    input  logic                      system_reset_n,
    input  logic                      bus_strobe_i,
    input  logic [15:0]               addr_i,
    input  logic                      rw_n_i,
    input  logic                      intcxrom_i,
    input  logic                      slotc3rom_i,
    input  logic [NUM_SLOTS-1:0]      slot_enable_i,
    input  logic [NUM_SLOTS-1:0]      rom_present_i,
    input  logic [NUM_SLOTS-1:0]      card_rd_en_i,
    input  logic [8*NUM_SLOTS-1:0]    card_data_i,
    input  logic [NUM_SLOTS-1:0]      card_irq_n_i,
    output logic [NUM_SLOTS-1:0]      rom_sel_o,
    output logic                      owner_valid_o,
    output logic [2:0]                owner_slot_o,
    output logic [7:0]                data_o,
    output logic                      rd_en_o,
    output logic                      conflict_o,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt_o,
    output logic                      irq_n_o,
    output logic [2:0]                irq_slot_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [2:0]                r_owner_slot;
    logic [2:0]                w_owner_nxt;
    logic [2:0]                w_cn_slot;
    logic                      w_cn_hit;
    logic                      w_cn_en;
    logic                      w_cn_rom;
    logic                      w_claim;
    logic                      w_owner_en;
    logic [NUM_SLOTS-1:0]      w_rom_sel;
    logic [NUM_SLOTS-1:0]      w_req;
    logic                      w_multi;
    logic [7:0]                w_win_data;
    logic [NUM_SLOTS-1:0]      w_pend;
    logic [2:0]                w_irq_slot;
    logic [7:0]                r_data;
    logic                      r_rd_en;
    logic                      r_conflict;
    logic [CONFLICT_CNT_W-1:0] r_cnt;
    logic                      r_irq_n;
    logic [2:0]                r_irq_slot;

    // $Cn00-$CnFF decode: n = addr[10:8] with addr[15:11] = 5'b11000
    assign w_cn_slot = addr_i[10:8];
    assign w_cn_hit  = (addr_i[15:11] == 5'b11000) && (w_cn_slot != 3'd0);

    always_comb begin
        w_cn_en    = 1'b0;
        w_cn_rom   = 1'b0;
        w_owner_en = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_cn_slot == 3'(i)) begin
                w_cn_en  = slot_enable_i[i];
                w_cn_rom = rom_present_i[i];
            end
            if (r_owner_slot == 3'(i)) begin
                w_owner_en = slot_enable_i[i];
            end
        end
    end

    // Slot 3 is shadowed by the internal ROM when slotc3rom_i is low
    assign w_claim = w_cn_hit && !intcxrom_i && w_cn_en && w_cn_rom &&
                     !((w_cn_slot == 3'd3) && !slotc3rom_i);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner_slot;
        if (bus_strobe_i && w_claim) begin
            w_state_nxt = S_OWNED;
            w_owner_nxt = w_cn_slot;
        end else if (bus_strobe_i && (addr_i == 16'hCFFF)) begin
            w_state_nxt = S_IDLE;
            w_owner_nxt = 3'd0;
        end else if ((r_state == S_OWNED) && !w_owner_en) begin
            w_state_nxt = S_IDLE;
            w_owner_nxt = 3'd0;
        end
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_state      <= S_IDLE;
            r_owner_slot <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner_slot <= w_owner_nxt;
        end
    end

    // $CFFF itself still falls in the window, so the owner stays selected for that access
    always_comb begin
        w_rom_sel = '0;
        if ((r_state == S_OWNED) && (addr_i[15:11] == 5'b11001) && !intcxrom_i) begin
            for (int i = 1; i < NUM_SLOTS; i++) begin
                if (r_owner_slot == 3'(i)) begin
                    w_rom_sel[i] = 1'b1;
                end
            end
        end
    end

    assign w_req   = card_rd_en_i & slot_enable_i & {NUM_SLOTS{rw_n_i}};
    assign w_multi = |(w_req & (w_req - {{(NUM_SLOTS-1){1'b0}}, 1'b1}));
    assign w_pend  = ~card_irq_n_i & slot_enable_i;

    // Scanning high to low leaves the lowest-numbered match as the result
    always_comb begin
        w_win_data = 8'hFF;
        w_irq_slot = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win_data = card_data_i[8*i +: 8];
            end
            if (w_pend[i]) begin
                w_irq_slot = 3'(i);
            end
        end
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_data     <= 8'hFF;
            r_rd_en    <= 1'b0;
            r_conflict <= 1'b0;
            r_cnt      <= '0;
            r_irq_n    <= 1'b1;
            r_irq_slot <= 3'd0;
        end else begin
            r_data     <= w_win_data;
            r_rd_en    <= |w_req;
            r_conflict <= w_multi;
            if (w_multi && !(&r_cnt)) begin
                r_cnt <= r_cnt + CONFLICT_CNT_W'(1);
            end
            r_irq_n    <= ~|w_pend;
            r_irq_slot <= w_irq_slot;
        end
    end

    assign rom_sel_o      = w_rom_sel;
    assign owner_valid_o  = (r_state == S_OWNED);
    assign owner_slot_o   = r_owner_slot;
    assign data_o         = r_data;
    assign rd_en_o        = r_rd_en;
    assign conflict_o     = r_conflict;
    assign conflict_cnt_o = r_cnt;
    assign irq_n_o        = r_irq_n;
    assign irq_slot_o     = r_irq_slot;

endmodule

// File: tb/tb_expansion_rom_arbiter.sv
// Directed bench for expansion_rom_arbiter: expectations are queued as stimulus
// is applied and checked once the registered outputs have updated.
module tb_expansion_rom_arbiter;

    localparam int NS = 8;

    logic            clk_logic = 1'b0;
    logic            system_reset_n;
    logic            bus_strobe_i;
    logic [15:0]     addr_i;
    logic            rw_n_i;
    logic            intcxrom_i;
    logic            slotc3rom_i;
    logic [NS-1:0]   slot_enable_i;
    logic [NS-1:0]   rom_present_i;
    logic [NS-1:0]   card_rd_en_i;
    logic [8*NS-1:0] card_data_i;
    logic [NS-1:0]   card_irq_n_i;
    logic [NS-1:0]   rom_sel_o;
    logic            owner_valid_o;
    logic [2:0]      owner_slot_o;
    logic [7:0]      data_o;
    logic            rd_en_o;
    logic            conflict_o;
    logic [7:0]      conflict_cnt_o;
    logic            irq_n_o;
    logic [2:0]      irq_slot_o;

    expansion_rom_arbiter #(.NUM_SLOTS(NS), .CONFLICT_CNT_W(8)) dut (
        .clk_logic      (clk_logic),
        .system_reset_n (system_reset_n),
        .bus_strobe_i   (bus_strobe_i),
        .addr_i         (addr_i),
        .rw_n_i         (rw_n_i),
        .intcxrom_i     (intcxrom_i),
        .slotc3rom_i    (slotc3rom_i),
        .slot_enable_i  (slot_enable_i),
        .rom_present_i  (rom_present_i),
        .card_rd_en_i   (card_rd_en_i),
        .card_data_i    (card_data_i),
        .card_irq_n_i   (card_irq_n_i),
        .rom_sel_o      (rom_sel_o),
        .owner_valid_o  (owner_valid_o),
        .owner_slot_o   (owner_slot_o),
        .data_o         (data_o),
        .rd_en_o        (rd_en_o),
        .conflict_o     (conflict_o),
        .conflict_cnt_o (conflict_cnt_o),
        .irq_n_o        (irq_n_o),
        .irq_slot_o     (irq_slot_o)
    );

    always #5 clk_logic = ~clk_logic;

    localparam int SEL_VALID = 0, SEL_OWNER = 1, SEL_DATA = 2, SEL_RDEN = 3,
                   SEL_CONF = 4, SEL_CNT = 5, SEL_IRQN = 6, SEL_IRQS = 7, SEL_ROMSEL = 8;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t q[$];
    int  checks   = 0;
    int  failures = 0;
    int  exp_cnt;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            SEL_VALID:  return {31'd0, owner_valid_o};
            SEL_OWNER:  return {29'd0, owner_slot_o};
            SEL_DATA:   return {24'd0, data_o};
            SEL_RDEN:   return {31'd0, rd_en_o};
            SEL_CONF:   return {31'd0, conflict_o};
            SEL_CNT:    return {24'd0, conflict_cnt_o};
            SEL_IRQN:   return {31'd0, irq_n_o};
            SEL_IRQS:   return {29'd0, irq_slot_o};
            default:    return {24'd0, rom_sel_o};
        endcase
    endfunction

    task automatic chk(input string tag, input int sel, input logic [31:0] exp);
        logic [31:0] o;
        o = obs(sel);
        checks++;
        assert (o === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        q.push_back(e);
    endtask

    task automatic step();
        sb_t e;
        @(posedge clk_logic);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, e.sel, e.exp);
        end
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_valid"}, SEL_VALID, 32'd0);
        chk({tag, "_owner"}, SEL_OWNER, 32'd0);
        chk({tag, "_data"},  SEL_DATA,  32'hFF);
        chk({tag, "_rden"},  SEL_RDEN,  32'd0);
        chk({tag, "_conf"},  SEL_CONF,  32'd0);
        chk({tag, "_cnt"},   SEL_CNT,   32'd0);
        chk({tag, "_irqn"},  SEL_IRQN,  32'd1);
        chk({tag, "_irqs"},  SEL_IRQS,  32'd0);
    endtask

    task automatic strobe_at(input logic [15:0] a);
        addr_i       = a;
        bus_strobe_i = 1'b1;
    endtask

    initial begin
        system_reset_n = 1'b0;
        bus_strobe_i   = 1'b0;
        addr_i         = 16'h0000;
        rw_n_i         = 1'b1;
        intcxrom_i     = 1'b0;
        slotc3rom_i    = 1'b1;
        slot_enable_i  = 8'hFF;
        rom_present_i  = 8'hFF;
        card_rd_en_i   = 8'h00;
        card_irq_n_i   = 8'hFF;
        for (int i = 0; i < NS; i++) card_data_i[8*i +: 8] = 8'(8'h11 * i);
        card_data_i[8*3 +: 8] = 8'hA5;
        card_data_i[8*5 +: 8] = 8'h5A;

        // Claim strobe held during reset must not be latched
        strobe_at(16'hC200);
        @(posedge clk_logic);
        @(posedge clk_logic);
        #1;
        reset_values("rst");
        system_reset_n = 1'b1;
        bus_strobe_i   = 1'b0;
        push("no_claim_in_rst", SEL_VALID, 32'd0);
        step();

        // Claim, window select, release
        strobe_at(16'hC200);
        push("claim2_slot", SEL_OWNER, 32'd2);
        push("claim2_valid", SEL_VALID, 32'd1);
        step();
        bus_strobe_i = 1'b0;
        addr_i = 16'hC900;
        #1 chk("romsel_c900", SEL_ROMSEL, 32'h04);
        strobe_at(16'hCFFF);
        #1 chk("romsel_cfff", SEL_ROMSEL, 32'h04);
        push("release_valid", SEL_VALID, 32'd0);
        push("release_slot", SEL_OWNER, 32'd0);
        step();
        bus_strobe_i = 1'b0;
        #1 chk("romsel_after_rel", SEL_ROMSEL, 32'h00);

        // Transfer and rejected claims
        strobe_at(16'hC200); push("reclaim2", SEL_OWNER, 32'd2); step();
        strobe_at(16'hC500); push("xfer5", SEL_OWNER, 32'd5); step();
        rom_present_i[6] = 1'b0;
        strobe_at(16'hC600); push("norom6", SEL_OWNER, 32'd5); step();
        rom_present_i[6] = 1'b1;
        slotc3rom_i = 1'b0;
        strobe_at(16'hC300); push("c3internal", SEL_OWNER, 32'd5); step();
        slotc3rom_i = 1'b1;
        strobe_at(16'hC300); push("c3card", SEL_OWNER, 32'd3); step();
        slot_enable_i[4] = 1'b0;
        strobe_at(16'hC400); push("disabled4", SEL_OWNER, 32'd3); step();
        slot_enable_i[4] = 1'b1;

        // Internal CX ROM blocks claims and window selects
        intcxrom_i = 1'b1;
        strobe_at(16'hC200); push("intcx_noclaim", SEL_OWNER, 32'd3); step();
        intcxrom_i = 1'b0;
        strobe_at(16'hC200); push("claim2b", SEL_OWNER, 32'd2); step();
        bus_strobe_i = 1'b0;
        intcxrom_i = 1'b1;
        addr_i = 16'hC900;
        #1 chk("romsel_intcx", SEL_ROMSEL, 32'h00);
        strobe_at(16'hCFFF); push("release_intcx", SEL_VALID, 32'd0); step();
        bus_strobe_i = 1'b0;
        intcxrom_i = 1'b0;

        // Read arbitration
        card_rd_en_i = 8'b0010_1000;
        push("rd_data", SEL_DATA, 32'hA5);
        push("rd_en", SEL_RDEN, 32'd1);
        push("rd_conf", SEL_CONF, 32'd1);
        push("rd_cnt1", SEL_CNT, 32'd1);
        step();
        card_rd_en_i = 8'h00;
        push("idle_data", SEL_DATA, 32'hFF);
        push("idle_rden", SEL_RDEN, 32'd0);
        push("idle_conf", SEL_CONF, 32'd0);
        push("idle_cnt", SEL_CNT, 32'd1);
        step();
        card_rd_en_i = 8'b0100_0000;
        push("single_data", SEL_DATA, 32'h66);
        push("single_conf", SEL_CONF, 32'd0);
        step();
        rw_n_i = 1'b0;
        card_rd_en_i = 8'b0010_1000;
        push("write_rden", SEL_RDEN, 32'd0);
        push("write_data", SEL_DATA, 32'hFF);
        push("write_conf", SEL_CONF, 32'd0);
        step();
        rw_n_i = 1'b1;
        slot_enable_i[3] = 1'b0;
        push("masked_data", SEL_DATA, 32'h5A);
        push("masked_conf", SEL_CONF, 32'd0);
        step();
        slot_enable_i[3] = 1'b1;

        exp_cnt = 1;
        for (int k = 0; k < 300; k++) begin
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
            push("sat_cnt", SEL_CNT, 32'(exp_cnt));
            step();
        end
        chk("sat_final", SEL_CNT, 32'd255);
        chk("sat_conf", SEL_CONF, 32'd1);
        card_rd_en_i = 8'h00;
        push("sat_hold", SEL_CNT, 32'd255);
        step();

        // Interrupt combining
        card_irq_n_i = 8'b1010_1111;
        push("irq46_n", SEL_IRQN, 32'd0);
        push("irq46_slot", SEL_IRQS, 32'd4);
        step();
        slot_enable_i[4] = 1'b0;
        push("irq6_slot", SEL_IRQS, 32'd6);
        step();
        slot_enable_i[4] = 1'b1;
        card_irq_n_i = 8'hFF;
        push("irq_none_n", SEL_IRQN, 32'd1);
        push("irq_none_slot", SEL_IRQS, 32'd0);
        step();
        card_irq_n_i = 8'hFE;
        push("irq0_n", SEL_IRQN, 32'd0);
        push("irq0_slot", SEL_IRQS, 32'd0);
        step();
        card_irq_n_i = 8'hFF;
        step();

        // Owner loses enable without any strobe
        strobe_at(16'hC200); push("claim2c", SEL_OWNER, 32'd2); step();
        bus_strobe_i = 1'b0;
        slot_enable_i[2] = 1'b0;
        push("en_drop_valid", SEL_VALID, 32'd0);
        push("en_drop_slot", SEL_OWNER, 32'd0);
        step();
        slot_enable_i[2] = 1'b1;

        // Asynchronous reset mid-cycle while owned and outputs active
        strobe_at(16'hC200);
        card_rd_en_i = 8'b0100_0000;
        card_irq_n_i = 8'b1110_1111;
        push("pre_rst_owner", SEL_OWNER, 32'd2);
        push("pre_rst_data", SEL_DATA, 32'h66);
        push("pre_rst_irq", SEL_IRQS, 32'd4);
        step();
        bus_strobe_i = 1'b0;
        addr_i = 16'hC900;
        #2 system_reset_n = 1'b0;
        #1;
        reset_values("async_rst");
        chk("async_rst_romsel", SEL_ROMSEL, 32'h00);
        @(posedge clk_logic);
        #1;
        chk("rst_hold_data", SEL_DATA, 32'hFF);
        system_reset_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
